// File: rtl/cicn_decimator_pkg.sv
// cic_pkg: shared helpers for the CIC decimator.
//   cic_out_width  - full-precision output width for a given configuration
//   cic_params_ok  - legality check on the parameter set, used at elaboration
package cic_pkg;

   function automatic int cic_out_width(input int order, input int r,
                                        input int bitstream, input int in_width);
      return (bitstream != 0) ? (order * $clog2(r) + 1)
                              : (in_width + order * $clog2(r));
   endfunction

   function automatic bit cic_params_ok(input int order, input int r,
                                        input int bitstream, input int in_width);
      return (order >= 1) && (order <= 6) &&
             (r >= 2) && ((r & (r - 1)) == 0) &&
             (in_width >= 1) &&
             ((bitstream == 0) || (in_width == 1));
   endfunction

endpackage

// File: rtl/cicn_decimator_if.sv
// cicn_decimator_if: sample input strobe plus valid/ready result output.
//   in_data/in_valid   - input sample and strobe (producer -> filter)
//   out_data/out_valid - decimated result and holding-register flag
//   out_ready          - consumer accept
//   overrun            - sticky flag, an untaken result was overwritten
// master = producer/consumer side, slave = filter side.
interface cicn_decimator_if #(
   parameter int IN_WIDTH  = 1,
   parameter int OUT_WIDTH = 25
);
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_valid;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 overrun;

   modport master (
      output in_data, in_valid, out_ready,
      input  out_data, out_valid, overrun
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output out_data, out_valid, overrun
   );
endinterface

// File: rtl/cicn_decimator_integrator.sv
// cic_integrator: one wrapping accumulator stage of the CIC integrator chain.
//   clk, reset (async, active-high), clear (sync)
//   en   - accumulate din this cycle
//   din  - stage input (previous stage's registered value)
//   acc  - accumulator value
module cic_integrator #(
   parameter int WIDTH = 25
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] acc
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + din;
      end
   end

endmodule

// File: rtl/cicn_decimator.sv
// cicn_decimator: order-N CIC (Hogenauer) decimator, single clock domain.
//   clk    - modulator-rate clock
//   reset  - async active-high, clears all state
//   clear  - sync clear, same effect as reset at the next edge
//   bus    - slave side of cicn_decimator_if (in_data/in_valid in,
//            out_data/out_valid/overrun out, out_ready in)
// Integrators run on every accepted sample; the combs and the output
// register are evaluated only in the cycle dec_strobe is high.
module cicn_decimator
   import cic_pkg::*;
#(
   parameter int ORDER             = 3,
   parameter int DECIMATION_FACTOR = 256,
   parameter int BITSTREAM         = 1,
   parameter int IN_WIDTH          = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clear,
   cicn_decimator_if.slave bus
);

   localparam int          L         = $clog2(DECIMATION_FACTOR);
   localparam int          OUT_WIDTH = cic_out_width(ORDER, DECIMATION_FACTOR,
                                                     BITSTREAM, IN_WIDTH);
   localparam int unsigned N_STAGES  = ORDER;

   if (!cic_params_ok(ORDER, DECIMATION_FACTOR, BITSTREAM, IN_WIDTH)) begin : g_bad_params
      $error("cicn_decimator: illegal ORDER/DECIMATION_FACTOR/BITSTREAM/IN_WIDTH");
   end

   // integ[0] is the extended input, integ[k] the k-th integrator
   logic [OUT_WIDTH-1:0] integ [0:N_STAGES];

   if (BITSTREAM != 0) begin : g_zext
      assign integ[0] = {{(OUT_WIDTH-1){1'b0}}, bus.in_data[0]};
   end else begin : g_sext
      assign integ[0] = OUT_WIDTH'($signed(bus.in_data));
   end

   for (genvar k = 1; k <= N_STAGES; k++) begin : g_int
      cic_integrator #(
         .WIDTH (OUT_WIDTH)
      ) u_int (
         .clk   (clk),
         .reset (reset),
         .clear (clear),
         .en    (bus.in_valid),
         .din   (integ[k-1]),
         .acc   (integ[k])
      );
   end

   logic [L-1:0]         count;
   logic                 dec_strobe;
   logic [OUT_WIDTH-1:0] dly  [1:N_STAGES];
   logic [OUT_WIDTH-1:0] comb [0:N_STAGES];
   logic [OUT_WIDTH-1:0] out_data_q;
   logic                 out_valid_q;
   logic                 overrun_q;

   always_comb begin
      comb[0] = integ[N_STAGES];
      for (int unsigned k = 1; k <= N_STAGES; k++) begin
         comb[k] = comb[k-1] - dly[k];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count       <= '0;
         dec_strobe  <= 1'b0;
         for (int unsigned k = 1; k <= N_STAGES; k++) dly[k] <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (clear) begin
         count       <= '0;
         dec_strobe  <= 1'b0;
         for (int unsigned k = 1; k <= N_STAGES; k++) dly[k] <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         // R is a power of two, so the counter wraps by itself
         dec_strobe <= 1'b0;
         if (bus.in_valid) begin
            count      <= count + 1'b1;
            dec_strobe <= (count == '1);
         end

         if (dec_strobe) begin
            for (int unsigned k = 1; k <= N_STAGES; k++) dly[k] <= comb[k-1];
            out_data_q  <= comb[N_STAGES];
            out_valid_q <= 1'b1;
            // a take in the same cycle frees the slot, so no overrun then
            if (out_valid_q && !bus.out_ready) overrun_q <= 1'b1;
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_cicn_decimator.sv
// tb_cicn_decimator: directed bench for cicn_decimator.
//   dut_a: ORDER=3, R=4, 1-bit bitstream input (OUT_WIDTH=7)
//   dut_b: ORDER=3, R=4, signed 4-bit input   (OUT_WIDTH=10)
module tb_cicn_decimator;
   import cic_pkg::*;

   localparam int OW_A = cic_out_width(3, 4, 1, 1);
   localparam int OW_B = cic_out_width(3, 4, 0, 4);

   logic clk = 1'b0;
   logic reset;
   logic clear_a;
   logic clear_b;

   int total = 0;
   int bad   = 0;
   int log_t [$];
   int log_v [$];
   int zsum;

   always #5 clk = ~clk;

   cicn_decimator_if #(.IN_WIDTH(1), .OUT_WIDTH(OW_A)) bus_a ();
   cicn_decimator_if #(.IN_WIDTH(4), .OUT_WIDTH(OW_B)) bus_b ();

   cicn_decimator #(
      .ORDER (3), .DECIMATION_FACTOR (4), .BITSTREAM (1), .IN_WIDTH (1)
   ) dut_a (
      .clk (clk), .reset (reset), .clear (clear_a), .bus (bus_a)
   );

   cicn_decimator #(
      .ORDER (3), .DECIMATION_FACTOR (4), .BITSTREAM (0), .IN_WIDTH (4)
   ) dut_b (
      .clk (clk), .reset (reset), .clear (clear_b), .bus (bus_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      log_t.delete();
      log_v.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      clear_log();
   endtask

   // n edges of dut_a stimulus; a sample every `period` cycles, either the
   // constant d or 1,0,1,0... over accepted samples; logs each out_valid cycle
   task automatic run_a(input int n, input int period, input bit alt, input logic d);
      int accepted = 0;
      for (int k = 1; k <= n; k++) begin
         bus_a.in_valid = (((k - 1) % period) == 0);
         bus_a.in_data  = alt ? ((accepted % 2) == 0) : d;
         if (bus_a.in_valid) accepted++;
         tick();
         if (bus_a.out_valid === 1'b1) begin
            log_t.push_back(k);
            log_v.push_back(int'(bus_a.out_data));
         end
      end
      bus_a.in_valid = 1'b0;
   endtask

   task automatic run_b(input int n, input int d);
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = 4'(d);
      repeat (n) tick();
      bus_b.in_valid = 1'b0;
   endtask

   initial begin
      reset           = 1'b1;
      clear_a         = 1'b0;
      clear_b         = 1'b0;
      bus_a.in_valid  = 1'b0;
      bus_a.in_data   = '0;
      bus_a.out_ready = 1'b1;
      bus_b.in_valid  = 1'b0;
      bus_b.in_data   = '0;
      bus_b.out_ready = 1'b1;
      tick();
      reset = 1'b0;

      check("rst_data_a",  bus_a.out_data,  0);
      check("rst_valid_a", bus_a.out_valid, 0);
      check("rst_ovr_a",   bus_a.overrun,   0);
      check("rst_data_b",  bus_b.out_data,  0);

      // constant 1: 4, 44, then 64 = R^3; pulses every 4 clk
      do_reset();
      run_a(21, 1, 1'b0, 1'b1);
      check("dc1_count",   log_t.size(), 5);
      check("dc1_first_t", log_t[0], 5);
      check("dc1_last_t",  log_t[4], 21);
      check("dc1_v0",      log_v[0], 4);
      check("dc1_v1",      log_v[1], 44);
      check("dc1_v3",      log_v[3], 64);
      check("dc1_v4",      log_v[4], 64);

      // alternating 1/0: steady half scale
      do_reset();
      run_a(21, 1, 1'b1, 1'b0);
      check("alt_count", log_t.size(), 5);
      check("alt_v3",    log_v[3], 32);
      check("alt_v4",    log_v[4], 32);

      // all zero
      do_reset();
      run_a(21, 1, 1'b0, 1'b0);
      zsum = 0;
      foreach (log_v[i]) zsum = zsum | log_v[i];
      check("zero_count", log_t.size(), 5);
      check("zero_vals",  zsum, 0);

      // sample every 3rd cycle: same values, 12 clk spacing
      do_reset();
      run_a(60, 3, 1'b0, 1'b1);
      check("gap_count",   log_t.size(), 5);
      check("gap_first_t", log_t[0], 11);
      check("gap_t1",      log_t[1], 23);
      check("gap_last_t",  log_t[4], 59);
      check("gap_v1",      log_v[1], 44);
      check("gap_v4",      log_v[4], 64);

      // signed input, integrators wrap over 1000 samples
      do_reset();
      run_b(5, -8);
      check("s_first", $signed(bus_b.out_data), -32);
      run_b(995, -8);
      tick();
      tick();
      check("s_neg", $signed(bus_b.out_data), -512);
      run_b(1000, 7);
      tick();
      tick();
      check("s_pos", $signed(bus_b.out_data), 448);

      // backpressure across two frames
      do_reset();
      bus_a.out_ready = 1'b0;
      run_a(8, 1, 1'b0, 1'b1);
      tick();
      check("bp_data",  bus_a.out_data,  44);
      check("bp_valid", bus_a.out_valid, 1);
      check("bp_ovr",   bus_a.overrun,   1);
      bus_a.out_ready = 1'b1;
      tick();
      bus_a.out_ready = 1'b0;
      check("bp_take_valid", bus_a.out_valid, 0);
      check("bp_take_ovr",   bus_a.overrun,   1);
      tick();
      check("bp_ovr_sticky", bus_a.overrun, 1);
      clear_a = 1'b1;
      tick();
      clear_a = 1'b0;
      check("clr_ovr",  bus_a.overrun,  0);
      check("clr_data", bus_a.out_data, 0);

      // take coinciding with a new result
      run_a(8, 1, 1'b0, 1'b1);
      bus_a.out_ready = 1'b1;
      tick();
      check("co_valid", bus_a.out_valid, 1);
      check("co_ovr",   bus_a.overrun,   0);
      check("co_data",  bus_a.out_data,  44);
      tick();
      check("co_after_valid", bus_a.out_valid, 0);

      // async reset mid-frame
      do_reset();
      bus_a.out_ready = 1'b1;
      run_a(5, 1, 1'b0, 1'b1);
      check("mr_pre_valid", bus_a.out_valid, 1);
      #1;
      reset = 1'b1;
      #1;
      check("mr_data",  bus_a.out_data,  0);
      check("mr_valid", bus_a.out_valid, 0);
      #2;
      reset = 1'b0;
      clear_log();
      run_a(5, 1, 1'b0, 1'b1);
      check("mr_count", log_t.size(), 1);
      check("mr_t",     log_t[0], 5);
      check("mr_v",     log_v[0], 4);

      // sync clear mid-frame
      clear_a        = 1'b1;
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 1'b1;
      #1;
      check("cl_hold_data", bus_a.out_data, 4);
      tick();
      check("cl_data",  bus_a.out_data,  0);
      check("cl_valid", bus_a.out_valid, 0);
      clear_a        = 1'b0;
      bus_a.in_valid = 1'b0;
      clear_log();
      run_a(5, 1, 1'b0, 1'b1);
      check("cl_count", log_t.size(), 1);
      check("cl_t",     log_t[0], 5);
      check("cl_v",     log_v[0], 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
